// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward controller for the 5-stage IF/ID/EX/MEM/WB core.
// Define PIPE_FORWARDING_EN for EX/MEM + MEM/WB forwarding; otherwise RAW hazards stall in ID.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  id_use_rs_i,
   input  logic                  id_use_rt_i,
   input  logic [REG_ADDR_W-1:0] ex_rs_i,
   input  logic [REG_ADDR_W-1:0] ex_rt_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  ex_regwrite_i,
   input  logic                  ex_memread_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_i,
   input  logic                  mem_regwrite_i,
   input  logic                  mem_memop_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic                  wb_regwrite_i,
   input  logic                  branch_taken_i,
   input  logic                  dmem_ready_i,
   output logic                  pc_en_o,
   output logic                  ifid_en_o,
   output logic                  idex_en_o,
   output logic                  exmem_en_o,
   output logic                  memwb_en_o,
   output logic                  ifid_flush_o,
   output logic                  exmem_flush_o,
   output logic                  idex_bubble_o,
   output logic [1:0]            fwd_a_o,
   output logic [1:0]            fwd_b_o,
   output logic [3:0]            stage_valid_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);
`ifdef PIPE_FORWARDING_EN
   localparam logic FWD_EN = 1'b1;
`else
   localparam logic FWD_EN = 1'b0;
`endif
   typedef enum logic {RUN, MEMWAIT} state_e;
   state_e state_q, state_d;
   logic [3:0] valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic ex_wr, mem_wr, wb_wr, rs_ex, rt_ex, rs_mem, rt_mem, data_hz, hold, flush, stall;
   assign ex_wr  = ex_regwrite_i & valid_q[1] & (ex_rd_i != '0);
   assign mem_wr = mem_regwrite_i & valid_q[2] & (mem_rd_i != '0);
   assign wb_wr  = wb_regwrite_i & valid_q[3] & (wb_rd_i != '0);
   assign rs_ex  = ex_wr & id_use_rs_i & (id_rs_i == ex_rd_i);
   assign rt_ex  = ex_wr & id_use_rt_i & (id_rt_i == ex_rd_i);
   assign rs_mem = mem_wr & id_use_rs_i & (id_rs_i == mem_rd_i);
   assign rt_mem = mem_wr & id_use_rt_i & (id_rt_i == mem_rd_i);
   // With forwarding only a load in EX can't supply its result in time.
   assign data_hz = FWD_EN ? ex_memread_i & (rs_ex | rt_ex) : rs_ex | rt_ex | rs_mem | rt_mem;
   assign hold  = !dmem_ready_i & ((state_q == MEMWAIT) | (mem_memop_i & valid_q[2]));
   assign flush = !hold & branch_taken_i & valid_q[2];
   assign stall = !hold & !flush & data_hz;
   assign pc_en_o       = !rst & !hold & !stall;
   assign ifid_en_o     = !hold & !stall;
   assign idex_en_o     = !hold;
   assign exmem_en_o    = !hold;
   assign memwb_en_o    = !hold;
   assign ifid_flush_o  = flush;
   assign exmem_flush_o = flush;
   assign idex_bubble_o = flush | stall;
   assign fwd_a_o = (!FWD_EN || ex_rs_i == '0) ? 2'b00 :
                    (mem_wr && mem_rd_i == ex_rs_i) ? 2'b10 :
                    (wb_wr && wb_rd_i == ex_rs_i) ? 2'b01 : 2'b00;
   assign fwd_b_o = (!FWD_EN || ex_rt_i == '0) ? 2'b00 :
                    (mem_wr && mem_rd_i == ex_rt_i) ? 2'b10 :
                    (wb_wr && wb_rd_i == ex_rt_i) ? 2'b01 : 2'b00;
   assign stage_valid_o = valid_q;
   assign stall_cnt_o   = cnt_q;
   always_comb begin
      state_d = hold ? MEMWAIT : RUN;
      valid_d = hold  ? valid_q :
                flush ? {valid_q[2], 3'b000} :
                stall ? {valid_q[2:1], 1'b0, valid_q[0]} :
                        {valid_q[2:0], if_valid_i};
      cnt_d   = (pc_en_o || &cnt_q) ? cnt_q : cnt_q + 1'b1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule
